// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
// Latency: byte accepted in IDLE -> tx_start next cycle; requesters are held off (ready=0) until the frame and guard gap end.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 4,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       arb_busy,
    output logic                       timeout_err,
    output logic [15:0]                frames_sent
);

    localparam int GW   = $clog2(NUM_REQ);
    localparam int WC_W = $clog2(BUSY_TIMEOUT + 1);
    localparam int GC_W = $clog2(GUARD_CYCLES + 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        GUARD
    } state_t;

    state_t            state;
    state_t            state_nxt;
    state_t            post_frame;
    logic [GW-1:0]     rr_ptr;
    logic [WC_W-1:0]   wait_cnt;
    logic [GC_W-1:0]   guard_cnt;
    logic [GW-1:0]     pick;
    logic              pick_vld;
    logic              accept;
    logic              do_timeout;
    logic              do_done;
    int                idx;

    // Rotating priority search starting at rr_ptr.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!pick_vld && req_valid[idx]) begin
                pick     = GW'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    assign accept   = !rst && (state == IDLE) && !tx_busy && pick_vld;
    assign arb_busy = (state != IDLE);

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[pick] = 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        do_timeout = 1'b0;
        do_done    = 1'b0;
        post_frame = (GUARD_CYCLES > 0) ? GUARD : IDLE;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (wait_cnt == WC_W'(BUSY_TIMEOUT)) begin
                    do_timeout = 1'b1;
                    state_nxt  = post_frame;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    do_done   = 1'b1;
                    state_nxt = post_frame;
                end
            end
            GUARD: begin
                if (guard_cnt == GC_W'(GUARD_CYCLES - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
            frames_sent <= '0;
            wait_cnt    <= '0;
            guard_cnt   <= '0;
        end else begin
            tx_start    <= accept;
            timeout_err <= do_timeout;
            if (accept) begin
                tx_data  <= req_data[pick*8 +: 8];
                grant_id <= pick;
                rr_ptr   <= (pick == GW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
            end
            if (state == START) begin
                wait_cnt <= WC_W'(1);
            end else if (state == WAIT_BUSY && !tx_busy && !do_timeout) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            // Guard counter runs only while in GUARD and restarts from zero on every entry.
            if (state == GUARD) begin
                guard_cnt <= guard_cnt + 1'b1;
            end else begin
                guard_cnt <= '0;
            end
            if (do_done) begin
                frames_sent <= frames_sent + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transmitter model, event logs and per-scenario checks against a rule-level model.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int BT = 4;
    localparam int G  = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*8-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic [1:0]     grant_id;
    logic           arb_busy;
    logic           timeout_err;
    logic [15:0]    frames_sent;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Transmitter model: mode 0 normal, 1 dead (never busy), 2 busy driven by man_busy.
    int tx_mode = 2;
    int busy_len = 3;
    int busy_left = 0;
    bit start_seen = 0;
    logic man_busy = 1'b0;

    int acc_idx[$], acc_cyc[$], acc_dat[$], acc_vld[$];
    int start_cyc[$], start_dat[$], start_gid[$];
    int to_cyc[$];
    int multihot = 0;
    int ready_cycles = 0;

    uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(BT), .GUARD_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .grant_id(grant_id), .arb_busy(arb_busy), .timeout_err(timeout_err),
        .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign tx_busy = (tx_mode == 2) ? man_busy : (busy_left > 0);

    always @(posedge clk) begin
        #1;
        if (tx_mode == 2) begin
            busy_left = 0;
            start_seen = 0;
        end else begin
            if (busy_left > 0) busy_left--;
            if (start_seen) begin
                busy_left = busy_len;
                start_seen = 0;
            end
            if (tx_mode == 0 && tx_start === 1'b1) start_seen = 1;
        end
    end

    always @(negedge clk) begin
        int gi;
        gi = -1;
        if (!rst) begin
            if ($countones(req_ready) > 1) multihot++;
            if (req_ready != '0) ready_cycles++;
            for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) gi = i;
            if (gi >= 0) begin
                acc_idx.push_back(gi);
                acc_cyc.push_back(cyc);
                acc_dat.push_back(int'(req_data[gi*8 +: 8]));
                acc_vld.push_back(int'(req_valid));
            end
        end
        if (tx_start === 1'b1) begin
            start_cyc.push_back(cyc);
            start_dat.push_back(int'(tx_data));
            start_gid.push_back(int'(grant_id));
        end
        if (timeout_err === 1'b1) to_cyc.push_back(cyc);
    end

    function automatic int model_pick(input int vld, input int ptr);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (vld[i]) return i;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tx_mode = 2;
        man_busy = 1'b0;
        req_valid = '0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tx_mode = 0;
    endtask

    task automatic wait_acc(input int target, input int bound);
        for (int i = 0; i < bound && acc_cyc.size() < target; i++) tick();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && (arb_busy || tx_busy); i++) tick();
    endtask

    task automatic test_reset();
        tx_mode = 2;
        rst = 1'b1;
        req_valid = '1;
        req_data = {$urandom, $urandom} & {N*8{1'b1}};
        repeat (3) tick();
        @(negedge clk);
        tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL rst_tx_start got=%b exp=0", tx_start); end
        tests++; if (arb_busy !== 1'b0) begin fails++; $display("FAIL rst_arb_busy got=%b exp=0", arb_busy); end
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL rst_grant_id got=%0d exp=0", grant_id); end
        tests++; if (frames_sent !== 16'd0) begin fails++; $display("FAIL rst_frames got=%0d exp=0", frames_sent); end
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL rst_timeout got=%b exp=0", timeout_err); end
        tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL rst_tx_data got=%0h exp=0", tx_data); end
        tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL rst_req_ready got=%b exp=0000", req_ready); end
        @(posedge clk);
        #1;
        req_valid = '0;
        rst = 1'b0;
        tx_mode = 0;
    endtask

    task automatic test_single();
        int a0, s0;
        logic [7:0] d3;
        do_reset();
        busy_len = 80;
        a0 = acc_cyc.size();
        s0 = start_cyc.size();
        req_data = {$urandom} & 32'hFFFF00FF | 32'h0000A500;
        req_valid = 4'b0010;
        wait_acc(a0 + 1, 20);
        tests++; if (acc_cyc.size() !== a0 + 1) begin fails++; $display("FAIL single_accept got=%0d exp=%0d", acc_cyc.size() - a0, 1); end
        d3 = 8'($urandom);
        req_data[31:24] = d3;
        req_valid = 4'b1000;
        if (acc_cyc.size() == a0 + 1) begin
            tests++; if (acc_idx[a0] !== 1) begin fails++; $display("FAIL single_idx got=%0d exp=1", acc_idx[a0]); end
            wait_acc(a0 + 2, 200);
            tests++; if (start_cyc.size() !== s0 + 1) begin fails++; $display("FAIL single_start_cnt got=%0d exp=1", start_cyc.size() - s0); end
            tests++; if (acc_cyc.size() !== a0 + 2) begin fails++; $display("FAIL single_second_accept got=%0d exp=2", acc_cyc.size() - a0); end
            if (start_cyc.size() == s0 + 1 && acc_cyc.size() == a0 + 2) begin
                tests++; if (start_cyc[s0] !== acc_cyc[a0] + 1) begin fails++; $display("FAIL single_start_cyc got=%0d exp=%0d", start_cyc[s0], acc_cyc[a0] + 1); end
                tests++; if (start_dat[s0] !== 8'hA5) begin fails++; $display("FAIL single_tx_data got=%0h exp=a5", start_dat[s0]); end
                tests++; if (start_gid[s0] !== 1) begin fails++; $display("FAIL single_grant_id got=%0d exp=1", start_gid[s0]); end
                tests++; if (frames_sent !== 16'd1) begin fails++; $display("FAIL single_frames got=%0d exp=1", frames_sent); end
                tests++; if (acc_cyc[a0 + 1] !== start_cyc[s0] + 80 + G + 2) begin fails++; $display("FAIL single_spacing got=%0d exp=%0d", acc_cyc[a0 + 1], start_cyc[s0] + 82 + G); end
                tests++; if (acc_idx[a0 + 1] !== 3 || acc_dat[a0 + 1] !== int'(d3)) begin fails++; $display("FAIL single_second got=%0d/%0h exp=3/%0h", acc_idx[a0 + 1], acc_dat[a0 + 1], d3); end
            end
        end
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        int a0, s0;
        logic [7:0] bytes [4];
        bytes = '{8'h10, 8'h21, 8'h32, 8'h43};
        do_reset();
        busy_len = $urandom_range(1, 5);
        a0 = acc_cyc.size();
        s0 = start_cyc.size();
        req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};
        req_valid = 4'b1111;
        wait_acc(a0 + 6, 400);
        req_valid = '0;
        wait_idle();
        tests++; if (acc_cyc.size() !== a0 + 6) begin fails++; $display("FAIL rr_accepts got=%0d exp=6", acc_cyc.size() - a0); end
        tests++; if (frames_sent !== 16'd6) begin fails++; $display("FAIL rr_frames got=%0d exp=6", frames_sent); end
        if (acc_cyc.size() == a0 + 6 && start_cyc.size() >= s0 + 6) begin
            for (int i = 0; i < 6; i++) begin
                tests++; if (acc_idx[a0 + i] !== i % 4) begin fails++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, acc_idx[a0 + i], i % 4); end
                tests++; if (start_dat[s0 + i] !== int'(bytes[i % 4])) begin fails++; $display("FAIL rr_data[%0d] got=%0h exp=%0h", i, start_dat[s0 + i], bytes[i % 4]); end
                if (i > 0) begin
                    tests++; if (acc_cyc[a0 + i] - acc_cyc[a0 + i - 1] !== busy_len + G + 3) begin fails++; $display("FAIL rr_spacing[%0d] got=%0d exp=%0d", i, acc_cyc[a0 + i] - acc_cyc[a0 + i - 1], busy_len + G + 3); end
                end
            end
        end
    endtask

    task automatic test_timeout();
        int a0, s0, t0, r;
        do_reset();
        tx_mode = 1;
        r = $urandom_range(0, N - 1);
        a0 = acc_cyc.size();
        s0 = start_cyc.size();
        t0 = to_cyc.size();
        req_data = {$urandom};
        req_data[r*8 +: 8] = 8'h5A;
        req_valid = 4'(1 << r);
        wait_acc(a0 + 1, 20);
        req_valid = '0;
        for (int i = 0; i < 40 && to_cyc.size() == t0; i++) tick();
        tests++; if (frames_sent !== 16'd0) begin fails++; $display("FAIL to_frames got=%0d exp=0", frames_sent); end
        tx_mode = 0;
        busy_len = 2;
        req_valid = 4'(1 << r);
        wait_acc(a0 + 2, 20);
        req_valid = '0;
        wait_idle();
        tests++; if (to_cyc.size() !== t0 + 1) begin fails++; $display("FAIL to_pulses got=%0d exp=1", to_cyc.size() - t0); end
        tests++; if (acc_cyc.size() !== a0 + 2) begin fails++; $display("FAIL to_reaccept got=%0d exp=2", acc_cyc.size() - a0); end
        if (to_cyc.size() == t0 + 1 && acc_cyc.size() == a0 + 2 && start_cyc.size() >= s0 + 1) begin
            tests++; if (to_cyc[t0] !== start_cyc[s0] + 1 + BT) begin fails++; $display("FAIL to_cycle got=%0d exp=%0d", to_cyc[t0], start_cyc[s0] + 1 + BT); end
            tests++; if (start_dat[s0] !== 8'h5A) begin fails++; $display("FAIL to_tx_data got=%0h exp=5a", start_dat[s0]); end
            tests++; if (acc_cyc[a0 + 1] !== to_cyc[t0] + G) begin fails++; $display("FAIL to_idle_return got=%0d exp=%0d", acc_cyc[a0 + 1], to_cyc[t0] + G); end
        end
        tests++; if (frames_sent !== 16'd1) begin fails++; $display("FAIL to_frames_after got=%0d exp=1", frames_sent); end
    endtask

    task automatic test_reset_mid();
        int a0;
        do_reset();
        busy_len = 80;
        a0 = acc_cyc.size();
        req_data = {$urandom};
        req_valid = 4'b1111;
        wait_acc(a0 + 1, 20);
        repeat (6) tick();
        tests++; if (arb_busy !== 1'b1) begin fails++; $display("FAIL mid_busy_before got=%b exp=1", arb_busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL mid_tx_start got=%b exp=0", tx_start); end
        tests++; if (arb_busy !== 1'b0) begin fails++; $display("FAIL mid_arb_busy got=%b exp=0", arb_busy); end
        tests++; if (frames_sent !== 16'd0) begin fails++; $display("FAIL mid_frames got=%0d exp=0", frames_sent); end
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL mid_grant_id got=%0d exp=0", grant_id); end
        a0 = acc_cyc.size();
        wait_acc(a0 + 1, 200);
        req_valid = '0;
        tests++; if (acc_cyc.size() !== a0 + 1) begin fails++; $display("FAIL mid_regrant got=%0d exp=1", acc_cyc.size() - a0); end
        else begin
            tests++; if (acc_idx[a0] !== 0) begin fails++; $display("FAIL mid_first_grant got=%0d exp=0", acc_idx[a0]); end
        end
    endtask

    task automatic test_foreign_busy();
        int a0, s0, rc0, d;
        do_reset();
        tx_mode = 2;
        man_busy = 1'b1;
        busy_len = 3;
        a0 = acc_cyc.size();
        s0 = start_cyc.size();
        rc0 = ready_cycles;
        req_data = {$urandom};
        req_valid = 4'b0100;
        repeat (10) tick();
        tests++; if (ready_cycles !== rc0) begin fails++; $display("FAIL fb_ready got=%0d exp=%0d", ready_cycles - rc0, 0); end
        tests++; if (start_cyc.size() !== s0) begin fails++; $display("FAIL fb_start got=%0d exp=0", start_cyc.size() - s0); end
        man_busy = 1'b0;
        tx_mode = 0;
        d = cyc;
        tick();
        req_valid = '0;
        tests++; if (acc_cyc.size() !== a0 + 1) begin fails++; $display("FAIL fb_accept got=%0d exp=1", acc_cyc.size() - a0); end
        else begin
            tests++; if (acc_cyc[a0] !== d || acc_idx[a0] !== 2) begin fails++; $display("FAIL fb_accept_when got=%0d/%0d exp=%0d/2", acc_cyc[a0], acc_idx[a0], d); end
            tests++; if (acc_dat[a0] !== int'(req_data[23:16])) begin fails++; $display("FAIL fb_data got=%0h exp=%0h", acc_dat[a0], req_data[23:16]); end
        end
        wait_idle();
    endtask

    task automatic test_random();
        int a0, s0, n, ptr, e;
        do_reset();
        busy_len = $urandom_range(1, 6);
        a0 = acc_cyc.size();
        s0 = start_cyc.size();
        ptr = 0;
        for (int c = 0; c < 500; c++) begin
            req_valid = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            req_data = {$urandom};
            tick();
        end
        req_valid = '0;
        wait_idle();
        n = acc_cyc.size() - a0;
        tests++; if (n < 5) begin fails++; $display("FAIL rnd_accepts got=%0d exp>=5", n); end
        tests++; if (start_cyc.size() - s0 !== n) begin fails++; $display("FAIL rnd_starts got=%0d exp=%0d", start_cyc.size() - s0, n); end
        tests++; if (int'(frames_sent) !== n) begin fails++; $display("FAIL rnd_frames got=%0d exp=%0d", frames_sent, n); end
        if (start_cyc.size() - s0 == n) begin
            for (int i = 0; i < n; i++) begin
                e = model_pick(acc_vld[a0 + i], ptr);
                ptr = (e + 1) % N;
                tests++; if (acc_idx[a0 + i] !== e) begin fails++; $display("FAIL rnd_grant[%0d] got=%0d exp=%0d", i, acc_idx[a0 + i], e); end
                tests++; if (start_cyc[s0 + i] !== acc_cyc[a0 + i] + 1 || start_dat[s0 + i] !== acc_dat[a0 + i] || start_gid[s0 + i] !== e) begin
                    fails++; $display("FAIL rnd_start[%0d] got=%0d/%0h/%0d exp=%0d/%0h/%0d", i, start_cyc[s0 + i], start_dat[s0 + i], start_gid[s0 + i], acc_cyc[a0 + i] + 1, acc_dat[a0 + i], e);
                end
                if (i > 0) begin
                    tests++; if (acc_cyc[a0 + i] - acc_cyc[a0 + i - 1] < busy_len + G + 3) begin fails++; $display("FAIL rnd_spacing[%0d] got=%0d exp>=%0d", i, acc_cyc[a0 + i] - acc_cyc[a0 + i - 1], busy_len + G + 3); end
                end
            end
        end
        tests++; if (multihot !== 0) begin fails++; $display("FAIL ready_multihot got=%0d exp=0", multihot); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_foreign_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
